// File: rtl/reg_file_32x32.sv
// 32-entry register file: one synchronous write port, two combinational read ports
// built from mux_32to1 instances. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.

module mux_32to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d [32],
  input  logic [4:0]   sel,
  output logic [W-1:0] y
);

  // 32:1 select of one register word
  always_comb begin
    y = {W{1'b0}};
    case (sel)
      5'd0:  y = d[0];
      5'd1:  y = d[1];
      5'd2:  y = d[2];
      5'd3:  y = d[3];
      5'd4:  y = d[4];
      5'd5:  y = d[5];
      5'd6:  y = d[6];
      5'd7:  y = d[7];
      5'd8:  y = d[8];
      5'd9:  y = d[9];
      5'd10: y = d[10];
      5'd11: y = d[11];
      5'd12: y = d[12];
      5'd13: y = d[13];
      5'd14: y = d[14];
      5'd15: y = d[15];
      5'd16: y = d[16];
      5'd17: y = d[17];
      5'd18: y = d[18];
      5'd19: y = d[19];
      5'd20: y = d[20];
      5'd21: y = d[21];
      5'd22: y = d[22];
      5'd23: y = d[23];
      5'd24: y = d[24];
      5'd25: y = d[25];
      5'd26: y = d[26];
      5'd27: y = d[27];
      5'd28: y = d[28];
      5'd29: y = d[29];
      5'd30: y = d[30];
      5'd31: y = d[31];
      default: y = {W{1'b0}};
    endcase
  end

endmodule

module reg_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [4:0]            ra1,
  input  logic [4:0]            ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [DATA_WIDTH-1:0] regs_r [32];
  logic [DATA_WIDTH-1:0] mux1_s;
  logic [DATA_WIDTH-1:0] mux2_s;
  logic [DATA_WIDTH-1:0] rd1_s;
  logic [DATA_WIDTH-1:0] rd2_s;
  logic                  wr_en_s;

  // A write to a hardwired r0 is dropped here, so r0 keeps its reset value forever.
  assign wr_en_s = we && !((ZERO_REG != 0) && (wa == 5'd0));

  // Final read-port value: reset and hardwired r0 win, then optional forwarding, then storage.
  function automatic logic [DATA_WIDTH-1:0] port_read(
    input logic                  rst_v,
    input logic                  wr_v,
    input logic [4:0]            wa_v,
    input logic [DATA_WIDTH-1:0] wd_v,
    input logic [4:0]            ra_v,
    input logic [DATA_WIDTH-1:0] stored_v
  );
    logic [DATA_WIDTH-1:0] v;
    v = stored_v;
    if (rst_v) begin
      v = {DATA_WIDTH{1'b0}};
    end else if ((ZERO_REG != 0) && (ra_v == 5'd0)) begin
      v = {DATA_WIDTH{1'b0}};
`ifdef REG_FILE_BYPASS_EN
    end else if (wr_v && (wa_v == ra_v)) begin
      v = wd_v;
`endif
    end else begin
      v = stored_v;
    end
    return v;
  endfunction

  // Register storage: asynchronous clear, synchronous write; reset has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      regs_r[wa] <= wd;
    end
  end

  mux_32to1 #(.W(DATA_WIDTH)) u_mux1 (
    .d   (regs_r),
    .sel (ra1),
    .y   (mux1_s)
  );

  mux_32to1 #(.W(DATA_WIDTH)) u_mux2 (
    .d   (regs_r),
    .sel (ra2),
    .y   (mux2_s)
  );

  // Read port 1 output conditioning
  always_comb begin
    rd1_s = {DATA_WIDTH{1'b0}};
    rd1_s = port_read(rst, wr_en_s, wa, wd, ra1, mux1_s);
  end

  // Read port 2 output conditioning
  always_comb begin
    rd2_s = {DATA_WIDTH{1'b0}};
    rd2_s = port_read(rst, wr_en_s, wa, wd, ra2, mux2_s);
  end

  assign rd1 = rd1_s;
  assign rd2 = rd2_s;

endmodule

// File: tb/tb_reg_file_32x32.sv
// Self-checking bench for reg_file_32x32: vector table, directed corner sequences and
// randomized traffic against an array model, on ZERO_REG=1 and ZERO_REG=0 instances.

module tb_reg_file_32x32;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we  = 1'b0;
  logic [4:0]  wa  = 5'd0;
  logic [31:0] wd  = 32'd0;
  logic [4:0]  ra1 = 5'd0;
  logic [4:0]  ra2 = 5'd0;
  logic [31:0] rd1_z, rd2_z, rd1_n, rd2_n;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_z [32];
  logic [31:0] m_n [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] en1;
  } vec_t;

  vec_t tbl [8];

  reg_file_32x32 #(.DATA_WIDTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_z), .rd2(rd2_z)
  );

  reg_file_32x32 #(.DATA_WIDTH(32), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read value from the spec rules: reset -> 0, hardwired r0 -> 0,
  // forwarding of an in-flight write when enabled, else stored contents.
  function automatic logic [31:0] model_rd(input bit zr, input logic [4:0] a);
    if (rst) return 32'd0;
    if (zr && a == 5'd0) return 32'd0;
    if (BYP && we && wa == a && !(zr && wa == 5'd0)) return wd;
    return zr ? m_z[a] : m_n[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_z[i] = 32'd0;
      m_n[i] = 32'd0;
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 5'd1,  32'h9,        5'd1, 5'd0,  32'h9,  32'h0,  32'h9};
    tbl[1] = '{1'b1, 5'd2,  32'hB,        5'd2, 5'd1,  32'hB,  32'h9,  32'hB};
    tbl[2] = '{1'b1, 5'd3,  32'hF,        5'd3, 5'd2,  32'hF,  32'hB,  32'hF};
    tbl[3] = '{1'b1, 5'd31, 32'h8,        5'd3, 5'd31, 32'hF,  32'h8,  32'hF};
    tbl[4] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0, 5'd0,  32'h0,  32'h0,  32'hFFFFFFFF};
    tbl[5] = '{1'b0, 5'd4,  32'h55,       5'd4, 5'd4,  32'h0,  32'h0,  32'h0};
    tbl[6] = '{1'b1, 5'd4,  32'hAA,       5'd4, 5'd4,  32'hAA, 32'hAA, 32'hAA};
    tbl[7] = '{1'b0, 5'd4,  32'h55,       5'd4, 5'd4,  32'hAA, 32'hAA, 32'hAA};

    // reset state: everything reads zero while rst is held
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      check("reset_rd1", rd1_z, 32'd0);
      check("reset_rd2_n", rd2_n, 32'd0);
    end
    rst = 1'b0;

    // table-driven vectors, checked just after the capturing edge
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      we = tbl[k].we; wa = tbl[k].wa; wd = tbl[k].wd;
      ra1 = tbl[k].ra1; ra2 = tbl[k].ra2;
      @(posedge clk); #1;
      check($sformatf("vec%0d_rd1", k), rd1_z, tbl[k].e1);
      check($sformatf("vec%0d_rd2", k), rd2_z, tbl[k].e2);
      check($sformatf("vec%0d_rd1_zr0", k), rd1_n, tbl[k].en1);
    end

    // asynchronous reset in mid-cycle clears before the next edge
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
    @(posedge clk); #1;
    we = 1'b0;
    check("pre_reset_r5", rd1_z, 32'hDEADBEEF);
    #2 rst = 1'b1;
    #1 check("async_clear_r5", rd1_z, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(i);
      #1;
      check("post_reset_rd1", rd1_z, 32'd0);
      check("post_reset_rd2_n", rd2_n, 32'd0);
    end

    // same-cycle read/write hazard
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h11;
    @(negedge clk);
    wd = 32'h22; ra1 = 5'd7;
    #1 check("hazard_pre_edge", rd1_z, BYP ? 32'h22 : 32'h11);
    @(posedge clk); #1;
    check("hazard_post_edge", rd1_z, 32'h22);
    @(negedge clk);
    we = 1'b0;

    // reset rising at the same edge as a write: write lost
    @(negedge clk);
    we = 1'b1; wa = 5'd9; wd = 32'h1234; ra1 = 5'd9;
    @(posedge clk);
    rst = 1'b1;
    #1 check("collision_in_reset", rd1_z, 32'd0);
    @(negedge clk);
    rst = 1'b0; we = 1'b0;
    #1;
    check("collision_r9", rd1_z, 32'd0);
    check("collision_r9_zr0", rd1_n, 32'd0);

    // randomized traffic against the array model
    @(negedge clk);
    rst = 1'b1; #1 rst = 1'b0;
    model_clear();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        check("rand_rst_rd1", rd1_z, 32'd0);
        check("rand_rst_rd2_n", rd2_n, 32'd0);
        model_clear();
        #1 rst = 1'b0;
      end
      #1;
      check("rand_rd1", rd1_z, model_rd(1'b1, ra1));
      check("rand_rd2", rd2_z, model_rd(1'b1, ra2));
      check("rand_rd1_zr0", rd1_n, model_rd(1'b0, ra1));
      check("rand_rd2_zr0", rd2_n, model_rd(1'b0, ra2));
      @(posedge clk);
      if (we && !rst) begin
        if (wa != 5'd0) m_z[wa] = wd;
        m_n[wa] = wd;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
